// File: rtl/vec_lane_pkg.sv
// Shared types and width helpers for the multi-lane vector execution block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vec_lane_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_MIN  = 4'd9,
        OP_MAX  = 4'd10,
        OP_MINU = 4'd11,
        OP_MAXU = 4'd12
    } vec_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lane_state_e;

    localparam int DEF_VLMAX     = 32;
    localparam int DEF_NUM_LANES = 4;

    // Width of a vector-length field able to hold 0..vlmax.
    function automatic int calc_vl_w(input int vlmax);
        return $clog2(vlmax + 1);
    endfunction

    // Width of the beat index; kept at least one bit for single-beat configs.
    function automatic int calc_beat_w(input int vlmax, input int lanes);
        int w;
        w = $clog2(vlmax / lanes);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int VL_W   = calc_vl_w(DEF_VLMAX);
    localparam int BEAT_W = calc_beat_w(DEF_VLMAX, DEF_NUM_LANES);

endpackage

// File: rtl/vector_elem_alu.sv
// Single-element integer ALU: add/sub/mul/logic/shifts/min/max on ELEN bits.
// Latency: purely combinational.
// Backpressure: none; result follows inputs.
module vector_elem_alu
    import vec_lane_pkg::*;
#(
    parameter int ELEN = 32
) (
    input  logic [3:0]      op,
    input  logic [ELEN-1:0] a,
    input  logic [ELEN-1:0] b,
    output logic [ELEN-1:0] result
);

    localparam int SH_W = $clog2(ELEN);

    logic [SH_W-1:0] sh;
    assign sh = b[SH_W-1:0];

    // Select the operation; unassigned codes produce zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << sh;
            OP_SRL:  result = a >> sh;
            OP_SRA:  result = $unsigned($signed(a) >>> sh);
            OP_MIN:  result = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  result = ($signed(a) > $signed(b)) ? a : b;
            OP_MINU: result = (a < b) ? a : b;
            OP_MAXU: result = (a > b) ? a : b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/vector_lane_array.sv
// Sequences one vector instruction across NUM_LANES element ALUs, one beat per cycle, with mask/tail enables.
// Latency: first beat registered one cycle after request accept; done pulses one cycle after the last beat handshake.
// Backpressure: out_ready low freezes the beat register; req_ready is low for the whole instruction.
module vector_lane_array
    import vec_lane_pkg::*;
#(
    parameter int ELEN      = 32,
    parameter int NUM_LANES = 4,
    parameter int VLMAX     = 32,
    localparam int VL_BITS   = calc_vl_w(VLMAX),
    localparam int BEAT_BITS = calc_beat_w(VLMAX, NUM_LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [3:0]                req_op,
    input  logic [VL_BITS-1:0]        req_vl,
    input  logic                      req_vm,
    input  logic [VLMAX-1:0]          req_mask,
    input  logic [VLMAX*ELEN-1:0]     req_vs1,
    input  logic [VLMAX*ELEN-1:0]     req_vs2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_LANES*ELEN-1:0] out_data,
    output logic [NUM_LANES-1:0]      out_be,
    output logic [BEAT_BITS-1:0]      out_beat,
    output logic                      out_last,
    output logic                      done
);

    lane_state_e state, state_n;

    logic [3:0]            op_q;
    logic                  vm_q;
    logic [VLMAX-1:0]      mask_q;
    logic [VLMAX*ELEN-1:0] vs1_q, vs2_q;
    logic [VL_BITS-1:0]    vl_q;
    logic [BEAT_BITS-1:0]  last_q;

    logic                  accept, load, finish, done_n;
    logic [VL_BITS-1:0]    vl_in;
    int                    nbeats_in;

    // Operand source: the live request while idle (beat 0), the latched copy while running.
    logic                  sel_idle;
    logic [3:0]            src_op;
    logic                  src_vm;
    logic [VLMAX-1:0]      src_mask;
    logic [VLMAX*ELEN-1:0] src_vs1, src_vs2;
    logic [VL_BITS-1:0]    src_vl;
    logic [BEAT_BITS-1:0]  src_last, nb;

    logic [ELEN-1:0]       lane_a   [NUM_LANES];
    logic [ELEN-1:0]       lane_b   [NUM_LANES];
    logic [ELEN-1:0]       lane_res [NUM_LANES];
    logic [NUM_LANES-1:0]  lane_act;
    logic [NUM_LANES*ELEN-1:0] beat_data;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign vl_in     = (req_vl > VL_BITS'(VLMAX)) ? VL_BITS'(VLMAX) : req_vl;
    assign nbeats_in = (int'(vl_in) + NUM_LANES - 1) / NUM_LANES;

    // Pick operands and the beat index that the next register load will present.
    always_comb begin
        sel_idle = (state == IDLE);
        src_op   = sel_idle ? req_op   : op_q;
        src_vm   = sel_idle ? req_vm   : vm_q;
        src_mask = sel_idle ? req_mask : mask_q;
        src_vs1  = sel_idle ? req_vs1  : vs1_q;
        src_vs2  = sel_idle ? req_vs2  : vs2_q;
        src_vl   = sel_idle ? vl_in    : vl_q;
        src_last = sel_idle ? BEAT_BITS'(nbeats_in - 1) : last_q;
        nb       = sel_idle ? '0 : out_beat + BEAT_BITS'(1);
    end

    // Slice the per-lane elements of the upcoming beat and decide which lanes write.
    always_comb begin : lane_sel
        int e;
        e        = 0;
        lane_act = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            e           = int'(nb) * NUM_LANES + l;
            lane_a[l]   = src_vs1[e*ELEN +: ELEN];
            lane_b[l]   = src_vs2[e*ELEN +: ELEN];
            lane_act[l] = (e < int'(src_vl)) && (src_vm || src_mask[e]);
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vector_elem_alu #(.ELEN(ELEN)) u_alu (
            .op     (src_op),
            .a      (lane_a[l]),
            .b      (lane_b[l]),
            .result (lane_res[l])
        );
    end

    // Zero the data of lanes that are masked off or in the tail.
    always_comb begin
        beat_data = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_act[l]) beat_data[l*ELEN +: ELEN] = lane_res[l];
        end
    end

    // Next-state and register-load decisions.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        finish  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (nbeats_in == 0) begin
                        done_n = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (out_last) begin
                        finish  = 1'b1;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Beat output register and done pulse; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_be    <= '0;
            out_beat  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_n;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= beat_data;
                out_be    <= lane_act;
                out_beat  <= nb;
                out_last  <= (nb == src_last);
            end else if (finish) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_be    <= '0;
                out_beat  <= '0;
                out_last  <= 1'b0;
            end
        end
    end

    // Capture the instruction on accept; state alone decides whether it is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= req_op;
            vm_q   <= req_vm;
            mask_q <= req_mask;
            vs1_q  <= req_vs1;
            vs2_q  <= req_vs2;
            vl_q   <= vl_in;
            last_q <= BEAT_BITS'(nbeats_in - 1);
        end
    end

endmodule

// File: tb/tb_vector_lane_array.sv
module tb_vector_lane_array;
    import vec_lane_pkg::*;

    localparam int ELEN  = 32;
    localparam int NL    = 4;
    localparam int VLMAX = 32;
    localparam int VW    = VL_W;
    localparam int BW    = BEAT_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [3:0]            req_op = '0;
    logic [VW-1:0]         req_vl = '0;
    logic                  req_vm = 1'b1;
    logic [VLMAX-1:0]      req_mask = '0;
    logic [VLMAX*ELEN-1:0] req_vs1 = '0;
    logic [VLMAX*ELEN-1:0] req_vs2 = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [NL*ELEN-1:0]    out_data;
    logic [NL-1:0]         out_be;
    logic [BW-1:0]         out_beat;
    logic                  out_last;
    logic                  done;

    vector_lane_array #(.ELEN(ELEN), .NUM_LANES(NL), .VLMAX(VLMAX)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_vl(req_vl), .req_vm(req_vm), .req_mask(req_mask),
        .req_vs1(req_vs1), .req_vs2(req_vs2), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_be(out_be), .out_beat(out_beat), .out_last(out_last),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [VLMAX*ELEN-1:0] vs1, vs2;

    // Per-instruction record of accepted beats and observed events.
    logic [NL*ELEN-1:0] r_data[$];
    logic [NL-1:0]      r_be[$];
    int                 r_idx[$];
    bit                 r_last[$];
    int                 r_cyc[$];
    int t_acc, done_cnt, done_cyc, first_vld, stall_err, rdy_err;
    bit timed_out, any_valid, rdy_at_done;

    // Reference ALU from the op definitions, on 32-bit elements.
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        int unsigned sh;
        sa = a; sb = b; sh = b % 32;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a * b;
            3:  return a & b;
            4:  return a | b;
            5:  return a ^ b;
            6:  return a << sh;
            7:  return a >> sh;
            8:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            9:  return (sa < sb) ? a : b;
            10: return (sa > sb) ? a : b;
            11: return (a < b) ? a : b;
            12: return (a > b) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    // Expected data and enables of beat b from the element activity rule.
    function automatic void ref_beat(input int b, input int op, input int vl, input bit vm,
                                     input logic [VLMAX-1:0] mask,
                                     output logic [NL*ELEN-1:0] d, output logic [NL-1:0] be);
        int evl;
        evl = (vl > VLMAX) ? VLMAX : vl;
        d = '0; be = '0;
        for (int l = 0; l < NL; l++) begin
            int e;
            e = b * NL + l;
            if (e < evl && (vm || mask[e])) begin
                be[l] = 1'b1;
                d[l*ELEN +: ELEN] = ref_alu(op, vs1[e*ELEN +: ELEN], vs2[e*ELEN +: ELEN]);
            end
        end
    endfunction

    // Issue one instruction and record what comes out until two cycles after done.
    // rmode: 0 = ready always high, 1 = ready toggles each cycle, 2 = random ready.
    task automatic run_instr(input logic [3:0] op, input int vl, input bit vm,
                             input logic [VLMAX-1:0] mask, input int rmode);
        int guard;
        bit held;
        logic [NL*ELEN-1:0] hd;
        logic [NL-1:0] hb;
        logic [BW-1:0] hi;
        logic hl;
        r_data.delete(); r_be.delete(); r_idx.delete(); r_last.delete(); r_cyc.delete();
        done_cnt = 0; done_cyc = -1; first_vld = -1; stall_err = 0; rdy_err = 0;
        timed_out = 1'b0; any_valid = 1'b0; rdy_at_done = 1'b0; held = 1'b0;
        hd = '0; hb = '0; hi = '0; hl = 1'b0;
        req_op = op; req_vl = VW'(vl); req_vm = vm; req_mask = mask;
        req_vs1 = vs1; req_vs2 = vs2; req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        t_acc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (guard < 400) begin
            if (held && (out_valid !== 1'b1 || out_data !== hd || out_be !== hb ||
                         out_beat !== hi || out_last !== hl)) stall_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; rdy_at_done = req_ready; end
            end
            if (out_valid === 1'b1) begin
                any_valid = 1'b1;
                if (first_vld < 0) first_vld = cyc;
                if (req_ready === 1'b1) rdy_err++;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            held = 1'b0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    r_data.push_back(out_data); r_be.push_back(out_be);
                    r_idx.push_back(int'(out_beat)); r_last.push_back(out_last);
                    r_cyc.push_back(cyc);
                end else begin
                    held = 1'b1; hd = out_data; hb = out_be; hi = out_beat; hl = out_last;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 400) timed_out = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0 || out_be !== '0) begin errors++; $display("FAIL reset_data_be got %h/%b want 0/0", out_data, out_be); end
        checks++; if (out_beat !== '0 || out_last !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_beat_last_done got %0d/%b/%b want 0/0/0", out_beat, out_last, done); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        logic [NL*ELEN-1:0] ed;
        for (int e = 0; e < VLMAX; e++) begin
            vs1[e*ELEN +: ELEN] = 32'(e);
            vs2[e*ELEN +: ELEN] = 32'd100;
        end
        run_instr(OP_ADD, 8, 1'b1, '0, 0);
        checks++; if (timed_out || r_data.size() != 2) begin errors++; $display("FAIL add_nbeats got %0d want 2", r_data.size()); end
        for (int b = 0; b < 2 && b < r_data.size(); b++) begin
            for (int l = 0; l < NL; l++) ed[l*ELEN +: ELEN] = 32'(100 + b*NL + l);
            checks++; if (r_data[b] !== ed) begin errors++; $display("FAIL add_data beat %0d got %h want %h", b, r_data[b], ed); end
            checks++; if (r_be[b] !== 4'hF) begin errors++; $display("FAIL add_be beat %0d got %b want 1111", b, r_be[b]); end
            checks++; if (r_last[b] !== (b == 1)) begin errors++; $display("FAIL add_last beat %0d got %b want %b", b, r_last[b], b == 1); end
            checks++; if (r_cyc[b] != t_acc + 1 + b) begin errors++; $display("FAIL add_beat_time beat %0d got %0d want %0d", b, r_cyc[b], t_acc + 1 + b); end
        end
        checks++; if (done_cyc != t_acc + 3 || done_cnt != 1) begin errors++; $display("FAIL add_done got cyc %0d cnt %0d want cyc %0d cnt 1", done_cyc, done_cnt, t_acc + 3); end
    endtask

    task automatic test_tail_mask();
        logic [NL*ELEN-1:0] ed0, ed1;
        for (int e = 0; e < VLMAX; e++) begin
            vs1[e*ELEN +: ELEN] = 32'd50;
            vs2[e*ELEN +: ELEN] = 32'd8;
        end
        ed0 = {32'd42, 32'd42, 32'd0, 32'd42};
        ed1 = {32'd0, 32'd0, 32'd42, 32'd0};
        run_instr(OP_SUB, 6, 1'b0, 32'h2D, 0);
        checks++; if (timed_out || r_data.size() != 2) begin errors++; $display("FAIL tail_nbeats got %0d want 2", r_data.size()); end
        if (r_data.size() == 2) begin
            checks++; if (r_be[0] !== 4'b1101 || r_data[0] !== ed0) begin errors++; $display("FAIL tail_beat0 got %b/%h want 1101/%h", r_be[0], r_data[0], ed0); end
            checks++; if (r_be[1] !== 4'b0010 || r_data[1] !== ed1) begin errors++; $display("FAIL tail_beat1 got %b/%h want 0010/%h", r_be[1], r_data[1], ed1); end
        end
    endtask

    task automatic test_ops_boundary();
        logic [3:0]  ops [5];
        logic [31:0] as [5];
        logic [31:0] bs [5];
        logic [31:0] ex [5];
        ops = '{OP_SRA, OP_MIN, OP_MINU, OP_MUL, 4'd14};
        as  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'd5};
        bs  = '{32'd33, 32'd1, 32'd1, 32'h00010000, 32'd7};
        ex  = '{32'hC0000000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            vs1 = '0; vs2 = '0;
            vs1[31:0] = as[i];
            vs2[31:0] = bs[i];
            run_instr(ops[i], 1, 1'b1, '0, 0);
            checks++;
            if (timed_out || r_data.size() != 1) begin
                errors++; $display("FAIL ops_nbeats case %0d got %0d want 1", i, r_data.size());
            end else if (r_data[0] !== {96'd0, ex[i]} || r_be[0] !== 4'b0001) begin
                errors++; $display("FAIL ops_result case %0d got %h/%b want %h/0001", i, r_data[0], r_be[0], ex[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NL*ELEN-1:0] ed;
        logic [NL-1:0] eb;
        for (int e = 0; e < VLMAX; e++) begin
            vs1[e*ELEN +: ELEN] = $urandom();
            vs2[e*ELEN +: ELEN] = $urandom();
        end
        run_instr(OP_XOR, 12, 1'b1, '0, 1);
        checks++; if (timed_out || r_data.size() != 3) begin errors++; $display("FAIL bp_nbeats got %0d want 3", r_data.size()); end
        for (int b = 0; b < r_data.size() && b < 3; b++) begin
            ref_beat(b, 5, 12, 1'b1, '0, ed, eb);
            checks++; if (r_idx[b] != b || r_data[b] !== ed || r_be[b] !== eb) begin errors++; $display("FAIL bp_beat %0d got idx %0d %h want idx %0d %h", b, r_idx[b], r_data[b], b, ed); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_err); end
        checks++; if (rdy_err != 0) begin errors++; $display("FAIL bp_req_ready_busy got %0d cycles want 0", rdy_err); end
        checks++; if (done_cnt != 1 || r_cyc.size() != 3 || done_cyc != r_cyc[r_cyc.size()-1] + 1) begin errors++; $display("FAIL bp_done got cnt %0d cyc %0d want cnt 1 after last handshake", done_cnt, done_cyc); end
    endtask

    task automatic test_vl_zero_clamp();
        logic [NL*ELEN-1:0] ed;
        logic [NL-1:0] eb;
        logic [VLMAX-1:0] m;
        run_instr(OP_ADD, 0, 1'b1, '0, 0);
        checks++; if (any_valid) begin errors++; $display("FAIL vl0_valid got 1 want 0"); end
        checks++; if (done_cyc != t_acc + 1 || done_cnt != 1) begin errors++; $display("FAIL vl0_done got cyc %0d cnt %0d want cyc %0d cnt 1", done_cyc, done_cnt, t_acc + 1); end
        checks++; if (rdy_at_done !== 1'b1) begin errors++; $display("FAIL vl0_ready got %b want 1", rdy_at_done); end
        for (int e = 0; e < VLMAX; e++) begin
            vs1[e*ELEN +: ELEN] = $urandom();
            vs2[e*ELEN +: ELEN] = $urandom();
        end
        m = $urandom();
        run_instr(OP_MAXU, 40, 1'b0, m, 0);
        checks++; if (timed_out || r_data.size() != 8) begin errors++; $display("FAIL clamp_nbeats got %0d want 8", r_data.size()); end
        if (r_data.size() == 8) begin
            checks++; if (r_idx[7] != 7 || r_last[7] !== 1'b1 || r_last[6] !== 1'b0) begin errors++; $display("FAIL clamp_last got idx %0d last %b want 7 1", r_idx[7], r_last[7]); end
        end
        for (int b = 0; b < r_data.size() && b < 8; b++) begin
            ref_beat(b, 12, 40, 1'b0, m, ed, eb);
            checks++; if (r_data[b] !== ed || r_be[b] !== eb) begin errors++; $display("FAIL clamp_beat %0d got %h/%b want %h/%b", b, r_data[b], r_be[b], ed, eb); end
        end
    endtask

    task automatic test_reset_mid_run();
        int guard;
        logic [NL*ELEN-1:0] ed;
        logic [NL-1:0] eb;
        for (int e = 0; e < VLMAX; e++) begin
            vs1[e*ELEN +: ELEN] = $urandom();
            vs2[e*ELEN +: ELEN] = $urandom();
        end
        out_ready = 1'b1;
        req_op = OP_ADD; req_vl = VW'(12); req_vm = 1'b1; req_mask = '0;
        req_vs1 = vs1; req_vs2 = vs2; req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!(out_valid === 1'b1 && out_beat === BW'(1)) && guard < 50) begin @(posedge clk); #1; guard++; end
        checks++; if (guard >= 50) begin errors++; $display("FAIL rstmid_wait_beat1 got timeout want beat 1"); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got vld %b done %b want 0 0", out_valid, done); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_reset got %b want 0", req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got %b want 1", req_ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got done %b vld %b want 0 0", done, out_valid); end
        run_instr(OP_ADD, 5, 1'b1, '0, 0);
        checks++; if (timed_out || r_data.size() != 2 || done_cnt != 1) begin errors++; $display("FAIL rstmid_after_nbeats got %0d want 2", r_data.size()); end
        for (int b = 0; b < r_data.size() && b < 2; b++) begin
            ref_beat(b, 0, 5, 1'b1, '0, ed, eb);
            checks++; if (r_data[b] !== ed || r_be[b] !== eb) begin errors++; $display("FAIL rstmid_after_beat %0d got %h/%b want %h/%b", b, r_data[b], r_be[b], ed, eb); end
        end
    endtask

    task automatic test_random();
        int op, vl, nb, evl;
        bit vm;
        logic [VLMAX-1:0] m;
        logic [NL*ELEN-1:0] ed;
        logic [NL-1:0] eb;
        for (int it = 0; it < 25; it++) begin
            op = $urandom_range(0, 15);
            vl = $urandom_range(0, 40);
            vm = 1'($urandom_range(0, 1));
            m  = $urandom();
            for (int e = 0; e < VLMAX; e++) begin
                vs1[e*ELEN +: ELEN] = (it % 3 == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom();
                vs2[e*ELEN +: ELEN] = (it % 3 == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom();
            end
            run_instr(4'(op), vl, vm, m, 2);
            evl = (vl > VLMAX) ? VLMAX : vl;
            nb  = (evl + NL - 1) / NL;
            checks++; if (timed_out || r_data.size() != nb) begin errors++; $display("FAIL rand_nbeats it %0d op %0d vl %0d got %0d want %0d", it, op, vl, r_data.size(), nb); end
            for (int b = 0; b < nb && b < r_data.size(); b++) begin
                ref_beat(b, op, vl, vm, m, ed, eb);
                checks++;
                if (r_data[b] !== ed || r_be[b] !== eb || r_idx[b] != b || r_last[b] !== (b == nb - 1)) begin
                    errors++; $display("FAIL rand_beat it %0d op %0d beat %0d got %h/%b idx %0d last %b want %h/%b idx %0d", it, op, b, r_data[b], r_be[b], r_idx[b], r_last[b], ed, eb, b);
                end
            end
            checks++; if (done_cnt != 1 || stall_err != 0 || rdy_err != 0) begin errors++; $display("FAIL rand_protocol it %0d got done %0d stall %0d busyrdy %0d want 1 0 0", it, done_cnt, stall_err, rdy_err); end
            checks++;
            if (nb == 0) begin
                if (any_valid || done_cyc != t_acc + 1) begin errors++; $display("FAIL rand_timing it %0d got done %0d want %0d", it, done_cyc, t_acc + 1); end
            end else if (r_cyc.size() != nb || first_vld != t_acc + 1 || done_cyc != r_cyc[nb-1] + 1) begin
                errors++; $display("FAIL rand_timing it %0d got first %0d done %0d want first %0d", it, first_vld, done_cyc, t_acc + 1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vs1 = '0;
        vs2 = '0;
        test_reset();
        test_add_basic();
        test_tail_mask();
        test_ops_boundary();
        test_backpressure();
        test_vl_zero_clamp();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_lane_array.md
# vector_lane_array

Parametrised, multi-lane successor to the single-element vector lane. Accepts one whole vector instruction (up to VLMAX elements of ELEN bits) per valid/ready request, then sequences it across NUM_LANES parallel element ALUs, one beat per cycle, with per-element masking, tail handling, an extended op set and output backpressure. It sits between the vector issue stage and the vector register-file write port.

## Interface
- ELEN, 32: element width in bits; power of two, ≥8.
- NUM_LANES, 4: elements processed per beat; must divide VLMAX.
- VLMAX, 32: maximum vector length in elements.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  4  operation code (vec_lane_pkg::vec_op_e).
- req_vl  in  $clog2(VLMAX+1)  active vector length.
- req_vm  in  1  1 = unmasked, 0 = use req_mask.
- req_mask  in  VLMAX  per-element mask, bit e applies to element e.
- req_vs1  in  VLMAX*ELEN  operand 1; element e is bits [e*ELEN +: ELEN].
- req_vs2  in  VLMAX*ELEN  operand 2, same packing.
- out_valid  out  1  beat present.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  NUM_LANES*ELEN  beat results; lane l is bits [l*ELEN +: ELEN].
- out_be  out  NUM_LANES  per-lane write enable.
- out_beat  out  $clog2(VLMAX/NUM_LANES)  beat index; element index = out_beat*NUM_LANES + lane.
- out_last  out  1  current beat is the final beat.
- done  out  1  one-cycle pulse when the instruction has retired.

## Operation
- States: IDLE and RUN. req_ready = (state == IDLE) and not rst.
- IDLE, on req_valid & req_ready:
  - Latch op, vm, mask, vs1, vs2.
  - Compute eff_vl = min(req_vl, VLMAX) and nbeats = ceil(eff_vl/NUM_LANES).
  - If nbeats = 0, stay IDLE and pulse done next cycle.
  - Otherwise load beat 0 into the output register and go to RUN.
- RUN:
  - out_valid = 1. Outputs hold stable while out_ready = 0.
  - On handshake of a non-last beat, load beat b+1.
  - On handshake with out_last = 1, clear out_valid, go to IDLE and pulse done the next cycle.
- Element e is active when e < eff_vl and (vm = 1 or mask[e] = 1).
- For an active element: out_be bit = 1 and data = ALU result.
- For an inactive element (masked off or tail): out_be bit = 0 and data = 0.
- Ops, all on ELEN bits with results truncated to ELEN:
  - ADD 0, SUB 1 (vs1 − vs2), MUL 2 (low ELEN bits), AND 3, OR 4, XOR 5.
  - SLL 6, SRL 7, SRA 8: shift amount = vs2[$clog2(ELEN)-1:0].
  - MIN 9 / MAX 10: signed. MINU 11 / MAXU 12: unsigned.
  - Codes 13–15: data 0; out_be still follows the mask rules.
- Reset in any state: go to IDLE and discard the latched instruction; no done pulse.

## Timing
- Reset values: req_ready 0 while rst is high, 1 afterwards. out_valid, out_data, out_be, out_beat, out_last and done are all 0.
- Request accepted at cycle T → beat 0 has out_valid = 1 at T+1.
- With out_ready held at 1, one beat per cycle; the last beat is at T+nbeats.
- Last beat handshake at cycle X → out_valid = 0 and done = 1 at X+1. req_ready is 1 at X+1, so the next request can be accepted at X+1 and its first beat appears at X+2.
- vl = 0 accepted at T → done = 1 at T+1. No beat is ever valid. req_ready = 1 at T+1.
- A stall (out_ready = 0) freezes beat index, data, be and last with no change in any output.
- ALU path is combinational from latched operands into the output register, so the beat register is the only pipeline stage.

## Structure
- vec_lane_pkg holds:
  - vec_op_e enum (4-bit codes above).
  - lane_state_e {IDLE, RUN}.
  - Width helper localparams: VL_W and BEAT_W derived from VLMAX and NUM_LANES.
- Sub-module vector_elem_alu (ELEN): combinational op/a/b → result, instantiated NUM_LANES times.
- The top level holds the FSM, operand latches, beat counter, mask/tail enable logic and output register.

## Test plan
- ADD, vl = 8, vm = 1, NUM_LANES = 4, vs1[e] = e, vs2[e] = 100, out_ready = 1:
  - Beats 0 and 1 at T+1 and T+2; data 100..107; out_be = 4'hF.
  - out_last only on beat 1; done at T+3.
- Tail and mask: SUB, vl = 6, vm = 0, mask = 0x2D (elements 0, 2, 3, 5), vs1 = 50, vs2 = 8:
  - Beat 0 be = 4'b1101 with data 42, 0, 42, 42.
  - Beat 1 be = 4'b0010 with data 0, 42, 0, 0.
- Ops boundary:
  - SRA of 0x80000000 by 33 gives 0xC0000000 (shift uses the low 5 bits, i.e. 1).
  - MIN(−1, 1) = 0xFFFFFFFF; MINU(0xFFFFFFFF, 1) = 1.
  - MUL 0x10000 × 0x10000 = 0.
  - op 14 gives data 0 with be set.
- Backpressure: vl = 12, out_ready toggles 0/1 each cycle:
  - Three beats delivered in order; outputs stable across stalls.
  - done exactly once, one cycle after the beat-2 handshake.
  - req_ready low until then.
- vl = 0, then vl = 40 clamped to 32:
  - First request: no out_valid, done at T+1.
  - Second request: 8 beats, last with out_beat = 7.
- Reset mid-RUN after beat 1 handshake:
  - Next cycle out_valid = 0, no done, req_ready = 1 once rst is released.
  - A new ADD request then completes normally.
